// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM s1 port arbiter: requester id, return tag, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DEF_AW / DEF_DW : default word-address and data widths of the shared BRAM
//   BE_W            : byteenable width for the default data width
//   req_id_t        : 1-bit requester identifier (0 = soft-core, 1 = host/MMIO)
//   rtag_t          : {valid, id} tag carried down the read-return pipeline
//   make_tag()      : builds a return tag
package bram_arb_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;
  localparam int BE_W   = DEF_DW / 8;

  typedef logic req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rtag_t;

  function automatic rtag_t make_tag(input logic valid, input req_id_t id);
    rtag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// Latency: grant is combinational from req and the pointer; pointer updates on the edge.
// Backpressure: none of its own; a non-granted requester simply sees no grant.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> m0 preferred)
//   req[1:0]     : request from requester 1 / requester 0
//   gnt[1:0]     : one-hot grant (or zero when nobody requests)
//   gnt_vld      : some requester is granted this cycle
//   gnt_id       : id of the granted requester (0 when nothing is granted)
module bram_arb_rr2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_vld,
  output req_id_t    gnt_id
);

  // rr names the requester that wins when both ask in the same cycle.
  req_id_t rr;

  always_comb begin
    gnt_id = ID_M0;
    if (req[0] && req[1]) begin
      gnt_id = rr;
    end else if (req[1]) begin
      gnt_id = ID_M1;
    end else begin
      gnt_id = ID_M0;
    end
  end

  assign gnt_vld = |req;
  assign gnt[0]  = gnt_vld && (gnt_id == ID_M0);
  assign gnt[1]  = gnt_vld && (gnt_id == ID_M1);

  // Pointing away from whoever just won makes two held requests alternate
  // every cycle; a lone requester keeps winning regardless of the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= ID_M0;
    end else if (gnt_vld) begin
      rr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port s1 between the soft-core bus (m0) and the host/MMIO path (m1).
// Latency: command is combinational to the BRAM; read data returns RD_LAT cycles after acceptance.
// Backpressure: the losing requester sees waitrequest and holds its command; the BRAM is never stalled.
//
// Ports:
//   clk, reset_n             : single clock, asynchronous active-low reset
//   mN_address/read/write    : Avalon-MM command from requester N (N = 0, 1)
//   mN_writedata/byteenable  : write payload and byte lanes from requester N
//   mN_waitrequest           : requester N's command was not taken this cycle
//   mN_readdata/valid        : read return to requester N (data shared, valid steered)
//   bram_*                   : command/response of BRAM slave port s1
//   conflict_cnt             : saturating count of cycles where both requesters asked
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1,      // BRAM read latency, 1 or 2
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [AW-1:0]     m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  input  logic [DW/8-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [AW-1:0]     m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  input  logic [DW/8-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,

  output logic [AW-1:0]     bram_address,
  output logic              bram_chipselect,
  output logic              bram_clken,
  output logic              bram_write,
  output logic [DW-1:0]     bram_writedata,
  output logic [DW/8-1:0]   bram_byteenable,
  input  logic [DW-1:0]     bram_readdata,

  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int BW = DW / 8;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_vld;
  req_id_t    gnt_id;

  assign req[0] = m0_read | m0_write;
  assign req[1] = m1_read | m1_write;

  bram_arb_rr2 u_rr2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign m0_waitrequest = req[0] & ~gnt[0];
  assign m1_waitrequest = req[1] & ~gnt[1];

  // ---------------------------------------------------------------------------
  // Command mux: the granted requester drives the BRAM port directly.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] sel_address;
  logic          sel_read;
  logic          sel_write;
  logic [DW-1:0] sel_writedata;
  logic [BW-1:0] sel_byteenable;
  logic          acc_read;

  always_comb begin
    sel_address    = '0;
    sel_read       = 1'b0;
    sel_write      = 1'b0;
    sel_writedata  = '0;
    sel_byteenable = '0;
    if (gnt_vld) begin
      if (gnt_id == ID_M1) begin
        sel_address    = m1_address;
        sel_read       = m1_read;
        sel_write      = m1_write;
        sel_writedata  = m1_writedata;
        sel_byteenable = m1_byteenable;
      end else begin
        sel_address    = m0_address;
        sel_read       = m0_read;
        sel_write      = m0_write;
        sel_writedata  = m0_writedata;
        sel_byteenable = m0_byteenable;
      end
    end
  end

  // Read+write together is taken as a write alone, so it must not enter the
  // return pipeline or the requester would see a spurious readdatavalid.
  assign acc_read = sel_read & ~sel_write;

  always_comb begin
    bram_address    = '0;
    bram_write      = 1'b0;
    bram_writedata  = '0;
    bram_byteenable = '0;
    if (gnt_vld) begin
      bram_address    = sel_address;
      bram_write      = sel_write;
      bram_writedata  = sel_writedata;
      bram_byteenable = sel_write ? sel_byteenable : {BW{1'b1}};
    end
  end

  assign bram_chipselect = gnt_vld;
  // The BRAM output register must keep moving so the tag pipeline stays aligned.
  assign bram_clken      = 1'b1;

  // ---------------------------------------------------------------------------
  // Read-return routing: a tag per issued cycle travels alongside the BRAM's
  // own read pipeline and tells which port the data at the end belongs to.
  // Clearing the tags on reset drops any reads still in flight.
  // ---------------------------------------------------------------------------
  rtag_t ret_pipe [RD_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        ret_pipe[i] <= '0;
      end
    end else begin
      ret_pipe[0] <= make_tag(acc_read, gnt_id);
      for (int i = 1; i < RD_LAT; i++) begin
        ret_pipe[i] <= ret_pipe[i-1];
      end
    end
  end

  rtag_t ret_tag;
  assign ret_tag = ret_pipe[RD_LAT-1];

  assign m0_readdatavalid = ret_tag.valid && (ret_tag.id == ID_M0);
  assign m1_readdatavalid = ret_tag.valid && (ret_tag.id == ID_M1);
  assign m0_readdata      = bram_readdata;
  assign m1_readdata      = bram_readdata;

  // ---------------------------------------------------------------------------
  // Conflict counter: saturates so a long-running system reads "very many"
  // rather than a small wrapped value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (req[0] && req[1] && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [AW-1:0]  m0_address, m1_address;
  logic           m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0]  m0_writedata, m1_writedata;
  logic [3:0]     m0_byteenable, m1_byteenable;
  logic           m0_waitrequest, m1_waitrequest;
  logic [DW-1:0]  m0_readdata, m1_readdata;
  logic           m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0]  bram_address;
  logic           bram_chipselect, bram_clken, bram_write;
  logic [DW-1:0]  bram_writedata;
  logic [3:0]     bram_byteenable;
  logic [DW-1:0]  bram_readdata;
  logic [CNT_W-1:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .bram_address(bram_address), .bram_chipselect(bram_chipselect),
    .bram_clken(bram_clken), .bram_write(bram_write),
    .bram_writedata(bram_writedata), .bram_byteenable(bram_byteenable),
    .bram_readdata(bram_readdata), .conflict_cnt(conflict_cnt)
  );

  // Behavioural BRAM s1 port, one cycle read latency, byte-lane writes.
  logic [DW-1:0] mem [0:1023] = '{default: '0};
  logic [DW-1:0] rd_q = '0;

  always @(posedge clk) begin
    if (bram_chipselect && bram_clken) begin
      if (bram_write) begin
        for (int b = 0; b < 4; b++)
          if (bram_byteenable[b]) mem[bram_address][8*b +: 8] <= bram_writedata[8*b +: 8];
      end else begin
        rd_q <= mem[bram_address];
      end
    end
  end
  assign bram_readdata = rd_q;

  // ---------------- drive helpers (no checking inside) ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] be);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] be);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, '0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Reset pulse placed mid-cycle, away from both clock edges.
  task automatic pulse_reset();
    idle_all();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_m0_rdv got=%b exp=0", m0_readdatavalid); end
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_m1_rdv got=%b exp=0", m1_readdatavalid); end
    total++; if (conflict_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    total++; if (bram_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", bram_chipselect); end
    total++; if (bram_clken !== 1'b1) begin bad++; $display("FAIL reset_clken got=%b exp=1", bram_clken); end
    total++; if (bram_address !== 10'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bram_address); end
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_m0_wait got=%b exp=0", m0_waitrequest); end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    drive_m0(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_m0_wait got=%b exp=0", m0_waitrequest); end
    total++; if (bram_write !== 1'b1) begin bad++; $display("FAIL wr_bram_write got=%b exp=1", bram_write); end
    total++; if (bram_address !== 10'h005) begin bad++; $display("FAIL wr_bram_addr got=%h exp=005", bram_address); end
    total++; if (bram_writedata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_bram_wdata got=%h exp=deadbeef", bram_writedata); end
    total++; if (bram_chipselect !== 1'b1) begin bad++; $display("FAIL wr_bram_cs got=%b exp=1", bram_chipselect); end
    next_cycle();
    drive_m0(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL rd_m0_wait got=%b exp=0", m0_waitrequest); end
    total++; if (bram_byteenable !== 4'hF) begin bad++; $display("FAIL rd_bram_be got=%h exp=f", bram_byteenable); end
    total++; if (bram_write !== 1'b0) begin bad++; $display("FAIL rd_bram_write got=%b exp=0", bram_write); end
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_no_rdv got=%b exp=0", m0_readdatavalid); end
    next_cycle();
    idle_all();
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL rd_m0_rdv got=%b exp=1", m0_readdatavalid); end
    total++; if (m0_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_m0_data got=%h exp=deadbeef", m0_readdata); end
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_m1_rdv got=%b exp=0", m1_readdatavalid); end
    next_cycle();
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_m0_rdv_once got=%b exp=0", m0_readdatavalid); end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [AW-1:0] exp_addr [4];
    logic          exp_w0   [4];
    logic          exp_w1   [4];
    exp_addr = '{10'h010, 10'h020, 10'h010, 10'h020};
    exp_w0   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_w1   = '{1'b1, 1'b0, 1'b1, 1'b0};
    // preload through the arbiter
    drive_m0(1'b0, 1'b1, 10'h010, 32'h11, 4'hF);
    next_cycle();
    drive_m0(1'b0, 1'b1, 10'h020, 32'h22, 4'hF);
    next_cycle();
    pulse_reset();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle_all();
      @(negedge clk);
      if (i < 4) begin
        total++; if (m0_waitrequest !== exp_w0[i]) begin bad++; $display("FAIL cf_m0_wait[%0d] got=%b exp=%b", i, m0_waitrequest, exp_w0[i]); end
        total++; if (m1_waitrequest !== exp_w1[i]) begin bad++; $display("FAIL cf_m1_wait[%0d] got=%b exp=%b", i, m1_waitrequest, exp_w1[i]); end
        total++; if (bram_address !== exp_addr[i]) begin bad++; $display("FAIL cf_addr[%0d] got=%h exp=%h", i, bram_address, exp_addr[i]); end
      end
      if (i == 0) begin
        total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin bad++; $display("FAIL cf_rdv0 got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
      end else if (i % 2 == 1) begin
        total++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h11)
          begin bad++; $display("FAIL cf_ret_m0[%0d] got=%b%b/%h exp=10/00000011", i, m0_readdatavalid, m1_readdatavalid, m0_readdata); end
      end else begin
        total++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h22)
          begin bad++; $display("FAIL cf_ret_m1[%0d] got=%b%b/%h exp=01/00000022", i, m0_readdatavalid, m1_readdatavalid, m1_readdata); end
      end
      next_cycle();
    end
    total++; if (conflict_cnt !== 4'd4) begin bad++; $display("FAIL cf_cnt got=%0d exp=4", conflict_cnt); end
  endtask

  task automatic test_partial_write();
    drive_m1(1'b0, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'h3);
    @(negedge clk);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL pw_m1_wait got=%b exp=0", m1_waitrequest); end
    total++; if (bram_byteenable !== 4'h3) begin bad++; $display("FAIL pw_be got=%h exp=3", bram_byteenable); end
    next_cycle();
    drive_m1(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0);
    next_cycle();
    idle_all();
    @(negedge clk);
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0000CCDD)
      begin bad++; $display("FAIL pw_readback got=%b/%h exp=1/0000ccdd", m1_readdatavalid, m1_readdata); end
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL pw_m0_rdv got=%b exp=0", m0_readdatavalid); end
    next_cycle();
  endtask

  task automatic test_read_and_write();
    drive_m0(1'b1, 1'b1, 10'h001, 32'h5, 4'hF);
    @(negedge clk);
    total++; if (bram_write !== 1'b1 || bram_writedata !== 32'h5 || bram_address !== 10'h001)
      begin bad++; $display("FAIL rw_cmd got=%b/%h/%h exp=1/00000005/001", bram_write, bram_writedata, bram_address); end
    next_cycle();
    idle_all();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
        begin bad++; $display("FAIL rw_no_rdv[%0d] got=%b exp=00", i, {m0_readdatavalid, m1_readdatavalid}); end
      next_cycle();
    end
    drive_m0(1'b1, 1'b0, 10'h001, 32'h0, 4'h0);
    next_cycle();
    idle_all();
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h5)
      begin bad++; $display("FAIL rw_readback got=%b/%h exp=1/00000005", m0_readdatavalid, m0_readdata); end
    next_cycle();
  endtask

  task automatic test_reset_abandon();
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL ra_m1_wait got=%b exp=0", m1_waitrequest); end
    next_cycle();
    idle_all();
    reset_n = 1'b0;
    #1;
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL ra_rdv_async got=%b exp=0", m1_readdatavalid); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
        begin bad++; $display("FAIL ra_no_rdv[%0d] got=%b exp=00", i, {m0_readdatavalid, m1_readdatavalid}); end
    end
    total++; if (conflict_cnt !== 4'h0) begin bad++; $display("FAIL ra_cnt got=%0d exp=0", conflict_cnt); end
    next_cycle();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1)
      begin bad++; $display("FAIL ra_first_grant got=%b%b exp=01", m0_waitrequest, m1_waitrequest); end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    pulse_reset();
    drive_m0(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      @(negedge clk);
      exp_cnt = (k > 15) ? 4'hF : 4'(k);
      total++; if (conflict_cnt !== exp_cnt)
        begin bad++; $display("FAIL sat_cnt[%0d] got=%h exp=%h", k, conflict_cnt, exp_cnt); end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    total++; if (conflict_cnt !== 4'hF) begin bad++; $display("FAIL sat_final got=%h exp=f", conflict_cnt); end
    next_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    test_reset();
    test_write_read();
    test_conflict();
    test_partial_write();
    test_read_and_write();
    test_reset_abandon();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one Avalon-MM slave port of the 1024x32 dual-port on-chip BRAM between two requesters.
  - Requester 0 is the soft-core data bus.
  - Requester 1 is the host/MMIO path.
- Round-robin arbitration, one command per cycle to the BRAM, read-data return routing via an in-flight tag pipeline, and a saturating conflict counter.
- Sits between the requesters and the BRAM s1 port. The BRAM s2 port stays dedicated elsewhere.

Parameters:
- AW, 10, word address width (1024 words).
- DW, 32, data width; byteenable width is DW/8.
- RD_LAT, 1, BRAM read latency in cycles from accepted command to valid data; legal values 1 or 2.
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  single clock for all logic and the BRAM port
- reset_n  in  1  asynchronous, active-low reset
- m0_address  in  AW  requester 0 word address
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DW  requester 0 write data
- m0_byteenable  in  DW/8  requester 0 byte lanes
- m0_waitrequest  out  1  requester 0 command not accepted this cycle
- m0_readdata  out  DW  requester 0 returned read data
- m0_readdatavalid  out  1  m0_readdata valid this cycle
- m1_*  same set as m0_*, for requester 1
- bram_address  out  AW  to BRAM s1 address
- bram_chipselect  out  1  to BRAM s1 chipselect
- bram_clken  out  1  to BRAM s1 clken
- bram_write  out  1  to BRAM s1 write
- bram_writedata  out  DW  to BRAM s1 writedata
- bram_byteenable  out  DW/8  to BRAM s1 byteenable
- bram_readdata  in  DW  from BRAM s1 readdata
- conflict_cnt  out  CNT_W  cycles in which both requesters requested

Behaviour:
- reqN = mN_read | mN_write.
- Grant is combinational from req0, req1 and the priority pointer rr (0 = m0 preferred).
  - Only one requester: it is granted.
  - Both requesters: the one indicated by rr is granted.
- rr update on a clock edge with a grant: rr <= ~granted_id. Otherwise rr holds. Both requesters held high therefore alternate every cycle.
- mN_waitrequest = reqN & ~grantN, combinational. A command is accepted in a cycle when reqN & ~mN_waitrequest.
  - Requesters hold address, data and controls stable while waitrequest is high.
- BRAM command outputs are combinational muxes of the granted requester.
  - bram_chipselect = any grant.
  - bram_write = granted write.
  - bram_byteenable = granted byteenable for writes, all ones for reads.
  - No grant: bram_address, bram_writedata and bram_byteenable output 0; bram_write 0.
- bram_clken is constant 1. The arbiter never stalls the BRAM output register.
- Read and write asserted together by one requester:
  - The command is treated as a write only.
  - No readdatavalid is produced for it.
- Return path is a RD_LAT-deep shift register of {valid, id}.
  - Stage 0 loads {accepted_read, granted_id} every cycle.
  - At the last stage, mN_readdatavalid = valid & (id == N).
  - m0_readdata and m1_readdata both carry bram_readdata; only the valid qualifies.
- Read latency is exactly RD_LAT cycles after acceptance. Back-to-back reads give full throughput, one return per cycle, returned in order.
- Writes produce no response and have no readdatavalid.
- Same-cycle read after write to the same address from the other requester is impossible: only one command per cycle is issued. The BRAM defines read-after-write ordering.
- conflict_cnt increments on each cycle with req0 & req1 and saturates at all ones. It never wraps.
- Reset (reset_n low, asynchronous):
  - rr = 0, all pipeline valid bits = 0, conflict_cnt = 0.
  - readdatavalid outputs = 0 immediately.
  - Commands issued before reset are abandoned; no readdatavalid is ever produced for them after reset releases.
- While reset_n is low, waitrequest follows the combinational rule. The bench does not issue requests during reset.

Decomposition:
- Shared package bram_arb_pkg:
  - Requester id typedef (1 bit).
  - Return-tag struct {valid, id}.
  - Localparam BE_W = DW/8.
- One sub-module, bram_arb_rr2: 2-way round-robin grant with pointer register.
- Return pipeline and muxing stay in the top level.

Test Plan:
- Reset, then m0 write addr 0x005 data 0xDEADBEEF be 0xF, then m0 read 0x005 -> m0_waitrequest 0 both cycles; m0_readdatavalid high exactly RD_LAT cycles after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Both requesters read (m0 at 0x010, m1 at 0x020, preloaded 0x11 and 0x22) held for 4 cycles after reset -> grants m0, m1, m0, m1; returns alternate 0x11/0x22 to the correct ports; conflict_cnt = 4.
- m1 write 0x3FF data 0xAABBCCDD be 0x3 over an old value of 0 -> readback gives 0x0000CCDD (lanes 2 and 3 untouched).
- m0 asserts read and write together at 0x001 with data 0x5 -> BRAM sees write 0x5; no readdatavalid on either port.
- Issue m1 read, assert reset_n low on the next cycle, release -> no readdatavalid after release; conflict_cnt = 0; first conflict after release grants m0.
- Force conflicts for 2^CNT_W + 3 cycles (CNT_W overridden to 4) -> conflict_cnt holds at 0xF.
